rr_input_arbiter: RTL and testbench
===================================

// Module: rr_input_arbiter
// PURPOSE
//  Packet-granular round-robin scheduler that shares one downstream AXI4-Stream datapath
//  (the filter/forwarding stage) among NUM_QUEUES RX queues. Each input is buffered in a
//  small FIFO. Whole packets are granted to one queue at a time, so beats never interleave.
//  Sits between the RX queues and the filtering module in the user datapath.
// PARAMETERS
//  C_M_AXIS_DATA_WIDTH   256  output tdata width (tkeep = /8)
//  C_S_AXIS_DATA_WIDTH   256  input tdata width; must equal C_M_AXIS_DATA_WIDTH
//  C_M_AXIS_TUSER_WIDTH  128  output tuser width
//  C_S_AXIS_TUSER_WIDTH  128  input tuser width; must equal C_M_AXIS_TUSER_WIDTH
//  NUM_QUEUES            4    number of input streams, fixed at 4 in this revision
//  FIFO_DEPTH_BITS       2    log2 of the depth of each input FIFO
// PORTS
//  axis_aclk              in   1     single clock for all logic
//  axis_resetn            in   1     asynchronous, active-low reset
//  s_axis_{0..3}_tdata    in   DW    input queue n data
//  s_axis_{0..3}_tkeep    in   DW/8  input queue n byte enables
//  s_axis_{0..3}_tuser    in   UW    input queue n metadata; passed through unmodified
//  s_axis_{0..3}_tvalid   in   1     input queue n valid
//  s_axis_{0..3}_tlast    in   1     input queue n end of packet
//  s_axis_{0..3}_tready   out  1     = !nearly_full of FIFO n
//  m_axis_tdata/tkeep/tuser out DW/DW/8/UW  granted queue's FIFO head
//  m_axis_tvalid          out  1     granted FIFO non-empty while in XFER
//  m_axis_tready          in   1     downstream ready
//  m_axis_tlast           out  1     granted FIFO head tlast
//  cur_grant              out  4     one-hot queue in XFER; 0 in IDLE
//  pkt_count              out  32    total packets forwarded; wraps at 2^32
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, cur_grant=0, pkt_count=0,
//   m_axis_tvalid=0, all FIFOs flushed. All m_axis data outputs are 0 outside XFER.
//  Write to FIFO n when s_axis_n_tvalid & s_axis_n_tready.
//  FSM IDLE: if any FIFO is non-empty, pick the first non-empty queue searching
//   rr_ptr, rr_ptr+1, ... mod 4. Register it as winner and go to XFER. No output
//   in IDLE, so there is 1 bubble cycle per packet.
//  FSM XFER: m_axis_* = winner FIFO head; tvalid = !empty[winner];
//   rd_en[winner] = tvalid & m_axis_tready. On a handshake with tlast=1:
//   rr_ptr <= winner+1 mod 4, pkt_count++, go to IDLE.
//  Queues other than the winner are never read while in XFER. An empty winner FIFO
//   mid-packet only deasserts tvalid; the grant is held (no timeout).
//  Latency: a beat written into an idle, empty arbiter appears on m_axis 2 cycles later
//   (FIFO fall-through at +1, grant registered at +1, valid at +2).
//  m_axis_tvalid must not drop once asserted while tready is low, except on reset.
//  The winner's FIFO may be written and read in the same cycle; nearly_full gives
//   one beat of margin, so there is no overflow.
//  Fairness: with all 4 queues backlogged, grants follow 0,1,2,3,0,...; each packet
//   is forwarded whole.
//  Reset mid-packet: the partial packet is discarded and tvalid drops immediately.
//   Downstream must tolerate a truncated packet at reset.
// STRUCTURE
//  Shared package: FSM state encodings (IDLE, XFER), NUM_QUEUES.
//  Sub-module: fallthrough_small_fifo, instantiated once per queue
//   (WIDTH = DW + UW + DW/8 + 1, MAX_DEPTH_BITS = FIFO_DEPTH_BITS).
//  Round-robin priority pick is a combinational function in this file.
// TESTING
//  1. Q2 only, 3-beat packet, tready=1 -> m_axis beats at cycles 2,3,4; cur_grant=4'b0100;
//     pkt_count=1; rr_ptr=3.
//  2. All 4 queues hold one 2-beat packet, rr_ptr=0 -> output order Q0,Q1,Q2,Q3; no
//     interleaving; one idle cycle between packets; pkt_count=4.
//  3. Q1 sends a 4-beat packet with m_axis_tready toggling 1,0,1,0 -> data stable while
//     stalled; 4 handshakes; Q0/Q3 traffic held off until tlast.
//  4. Q0 stalls upstream mid-packet (FIFO empty) while Q3 is full -> tvalid=0, grant stays
//     on Q0, s_axis_3_tready=0; Q3 granted right after Q0 tlast.
//  5. axis_resetn low during beat 2 of 5 -> outputs go to 0 asynchronously; after
//     release state=IDLE, pkt_count=0, all tready=1 the cycle after release.
//  6. Force pkt_count=32'hFFFF_FFFF, send 1 packet -> pkt_count=0.

Source files
------------

// File: rtl/rr_input_arbiter_pkg.sv
// rr_input_arbiter_pkg: shared queue count, queue index type and FSM encoding
package rr_input_arbiter_pkg;
    localparam int NUM_QUEUES = 4;
    localparam int QW = $clog2(NUM_QUEUES);
    typedef logic [QW-1:0] qidx_t;
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
endpackage

// File: rtl/rr_input_arbiter_if.sv
// rr_input_arbiter_if: AXI4-Stream bundle with master/slave views
interface rr_input_arbiter_if #(
    parameter int DW = 256,
    parameter int UW = 128
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tlast;
    logic            tready;
    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rr_input_arbiter_fifo.sv
// rr_input_arbiter_fifo: small fall-through FIFO, head visible whenever non-empty
module rr_input_arbiter_fifo #(
    parameter int WIDTH          = 1,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_nearly_full
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    assign o_dout        = r_mem[r_rd_ptr];
    assign o_empty       = (r_count == '0);
    assign o_nearly_full = (r_count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
    // storage array, no reset needed since reads are gated by the count
    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[r_wr_ptr] <= i_din;
    end
    // pointers and occupancy; nearly_full keeps one slot of margin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (MAX_DEPTH_BITS+1)'(i_wr_en) - (MAX_DEPTH_BITS+1)'(i_rd_en);
        end
    end
endmodule

// File: rtl/rr_input_arbiter.sv
// rr_input_arbiter: packet-granular round-robin merge of four AXI4-Stream queues
module rr_input_arbiter
    import rr_input_arbiter_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH_BITS      = 2
) (
    input  logic                  axis_aclk,
    input  logic                  axis_resetn,
    rr_input_arbiter_if.slave     s_axis_0,
    rr_input_arbiter_if.slave     s_axis_1,
    rr_input_arbiter_if.slave     s_axis_2,
    rr_input_arbiter_if.slave     s_axis_3,
    rr_input_arbiter_if.master    m_axis,
    output logic [NUM_QUEUES-1:0] o_cur_grant,
    output logic [31:0]           o_pkt_count
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int W  = DW + UW + DW/8 + 1;

    // first non-empty queue at or after ptr, wrapping
    function automatic qidx_t rr_pick(input qidx_t ptr, input logic [NUM_QUEUES-1:0] ne);
        qidx_t idx;
        rr_pick = ptr;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            idx = ptr + QW'(i);
            if (ne[idx]) rr_pick = idx;
        end
    endfunction

    logic [W-1:0]            w_din  [NUM_QUEUES];
    logic [W-1:0]            w_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   w_in_valid, w_wr_en, w_rd_en, w_empty, w_nearly_full;
    logic [W-1:0]            w_head;
    logic                    w_xfer, w_valid, w_last_hs;
    qidx_t                   w_pick;
    state_t                  r_state;
    qidx_t                   r_winner, r_rr_ptr;
    logic [NUM_QUEUES-1:0]   r_cur_grant;
    logic [31:0]             r_pkt_count;

    assign w_din[0] = {s_axis_0.tlast, s_axis_0.tkeep, s_axis_0.tuser, s_axis_0.tdata};
    assign w_din[1] = {s_axis_1.tlast, s_axis_1.tkeep, s_axis_1.tuser, s_axis_1.tdata};
    assign w_din[2] = {s_axis_2.tlast, s_axis_2.tkeep, s_axis_2.tuser, s_axis_2.tdata};
    assign w_din[3] = {s_axis_3.tlast, s_axis_3.tkeep, s_axis_3.tuser, s_axis_3.tdata};
    assign w_in_valid = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
    assign s_axis_0.tready = !w_nearly_full[0];
    assign s_axis_1.tready = !w_nearly_full[1];
    assign s_axis_2.tready = !w_nearly_full[2];
    assign s_axis_3.tready = !w_nearly_full[3];
    assign w_wr_en = w_in_valid & ~w_nearly_full;

    for (genvar n = 0; n < NUM_QUEUES; n++) begin : g_q
        assign w_rd_en[n] = w_valid && m_axis.tready && (r_winner == QW'(n));
        rr_input_arbiter_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
            .i_clk         (axis_aclk),
            .i_rst_n       (axis_resetn),
            .i_din         (w_din[n]),
            .i_wr_en       (w_wr_en[n]),
            .i_rd_en       (w_rd_en[n]),
            .o_dout        (w_dout[n]),
            .o_empty       (w_empty[n]),
            .o_nearly_full (w_nearly_full[n])
        );
    end

    assign w_head    = w_dout[r_winner];
    assign w_xfer    = (r_state == XFER);
    assign w_valid   = w_xfer && !w_empty[r_winner];
    assign w_last_hs = w_valid && m_axis.tready && w_head[W-1];
    assign w_pick    = rr_pick(r_rr_ptr, ~w_empty);

    assign m_axis.tvalid = w_valid;
    assign m_axis.tdata  = w_xfer ? w_head[0 +: C_M_AXIS_DATA_WIDTH] : '0;
    assign m_axis.tuser  = w_xfer ? w_head[DW +: C_M_AXIS_TUSER_WIDTH] : '0;
    assign m_axis.tkeep  = w_xfer ? w_head[DW+UW +: C_M_AXIS_DATA_WIDTH/8] : '0;
    assign m_axis.tlast  = w_xfer && w_head[W-1];
    assign o_cur_grant   = r_cur_grant;
    assign o_pkt_count   = r_pkt_count;

    // grant FSM: pick a winner in IDLE, hold it in XFER until its tlast handshake
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state     <= IDLE;
            r_winner    <= '0;
            r_rr_ptr    <= '0;
            r_cur_grant <= '0;
            r_pkt_count <= '0;
        end else if (r_state == IDLE) begin
            if (!(&w_empty)) begin
                r_state     <= XFER;
                r_winner    <= w_pick;
                r_cur_grant <= NUM_QUEUES'(1) << w_pick;
            end
        end else if (w_last_hs) begin
            r_state     <= IDLE;
            r_rr_ptr    <= r_winner + 1'b1;
            r_cur_grant <= '0;
            r_pkt_count <= r_pkt_count + 1;
        end
    end
endmodule

// File: tb/tb_rr_input_arbiter.sv
// tb_rr_input_arbiter: directed checks of grant order, stalls, reset and counter wrap
module tb_rr_input_arbiter;
    import rr_input_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] r_data [4];
    logic [127:0] r_user [4];
    logic [31:0]  r_keep [4];
    logic         r_valid [4];
    logic         r_last [4];
    logic [3:0]   w_s_ready;
    logic         r_m_ready;
    logic [3:0]   w_grant;
    logic [31:0]  w_pkt;
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    rr_input_arbiter_if #(.DW(256), .UW(128)) s_if [4] ();
    rr_input_arbiter_if #(.DW(256), .UW(128)) m_if ();

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign s_if[g].tdata  = r_data[g];
        assign s_if[g].tuser  = r_user[g];
        assign s_if[g].tkeep  = r_keep[g];
        assign s_if[g].tvalid = r_valid[g];
        assign s_if[g].tlast  = r_last[g];
        assign w_s_ready[g]   = s_if[g].tready;
    end
    assign m_if.tready = r_m_ready;

    rr_input_arbiter dut (
        .axis_aclk   (clk),
        .axis_resetn (rst_n),
        .s_axis_0    (s_if[0]),
        .s_axis_1    (s_if[1]),
        .s_axis_2    (s_if[2]),
        .s_axis_3    (s_if[3]),
        .m_axis      (m_if),
        .o_cur_grant (w_grant),
        .o_pkt_count (w_pkt)
    );

    function automatic logic [255:0] bd(input int q, input int b);
        return 256'(32'h0D00_0000 | (q << 8) | b);
    endfunction

    function automatic logic [127:0] bu(input int q, input int b);
        return 128'(32'h0CAF_0000 | (q << 8) | b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int q, input int b, input logic last);
        r_valid[q] = 1'b1;
        r_data[q]  = bd(q, b);
        r_user[q]  = bu(q, b);
        r_last[q]  = last;
        r_keep[q]  = last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endtask

    task automatic idle_q(input int q);
        r_valid[q] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int q, input int b, input logic last);
        chk({tag, "_valid"}, 256'(m_if.tvalid), 256'(1'b1));
        chk({tag, "_data"},  m_if.tdata, bd(q, b));
        chk({tag, "_user"},  256'(m_if.tuser), 256'(bu(q, b)));
        chk({tag, "_keep"},  256'(m_if.tkeep), 256'(last ? 32'h0000_FFFF : 32'hFFFF_FFFF));
        chk({tag, "_last"},  256'(m_if.tlast), 256'(last));
    endtask

    initial begin
        rst_n = 1'b0;
        r_m_ready = 1'b0;
        for (int q = 0; q < 4; q++) begin
            r_valid[q] = 1'b0;
            r_last[q]  = 1'b0;
            r_data[q]  = '0;
            r_user[q]  = '0;
            r_keep[q]  = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_valid", 256'(m_if.tvalid), 256'(1'b0));
        chk("rst_grant", 256'(w_grant), 256'(4'b0000));
        chk("rst_pkt",   256'(w_pkt), 256'(32'd0));
        chk("rst_data",  m_if.tdata, 256'(0));
        chk("rst_ready", 256'(w_s_ready), 256'(4'hF));

        // Q2 alone, 3-beat packet, downstream always ready
        r_m_ready = 1'b1;
        drive(2, 0, 1'b0);
        tick();
        chk("t1_bubble", 256'(m_if.tvalid), 256'(1'b0));
        drive(2, 1, 1'b0);
        tick();
        chk_beat("t1_b0", 2, 0, 1'b0);
        chk("t1_grant", 256'(w_grant), 256'(4'b0100));
        drive(2, 2, 1'b1);
        tick();
        idle_q(2);
        chk_beat("t1_b1", 2, 1, 1'b0);
        tick();
        chk_beat("t1_b2", 2, 2, 1'b1);
        tick();
        chk("t1_end_valid", 256'(m_if.tvalid), 256'(1'b0));
        chk("t1_end_grant", 256'(w_grant), 256'(4'b0000));
        chk("t1_end_data",  m_if.tdata, 256'(0));
        chk("t1_pkt",       256'(w_pkt), 256'(32'd1));
        chk("t1_rr_ptr",    256'(dut.r_rr_ptr), 256'(2'd3));
        drive(3, 0, 1'b1);
        tick();
        idle_q(3);
        tick();
        chk_beat("t1_q3", 3, 0, 1'b1);
        chk("t1_q3_grant", 256'(w_grant), 256'(4'b1000));
        tick();
        chk("t1_q3_ptr", 256'(dut.r_rr_ptr), 256'(2'd0));
        chk("t1_q3_pkt", 256'(w_pkt), 256'(32'd2));

        // all four queues hold a 2-beat packet, served 0,1,2,3 with a gap between
        r_m_ready = 1'b0;
        for (int q = 0; q < 4; q++) drive(q, 0, 1'b0);
        tick();
        for (int q = 0; q < 4; q++) drive(q, 1, 1'b1);
        tick();
        for (int q = 0; q < 4; q++) idle_q(q);
        r_m_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            chk_beat($sformatf("t2_q%0d_b0", p), p, 0, 1'b0);
            chk($sformatf("t2_q%0d_grant", p), 256'(w_grant), 256'(4'b0001 << p));
            tick();
            chk_beat($sformatf("t2_q%0d_b1", p), p, 1, 1'b1);
            tick();
            chk($sformatf("t2_q%0d_gap", p), 256'(m_if.tvalid), 256'(1'b0));
            tick();
        end
        chk("t2_pkt", 256'(w_pkt), 256'(32'd6));

        // Q1 4-beat packet under a toggling tready; Q0/Q3 wait for its tlast
        r_m_ready = 1'b0;
        drive(1, 0, 1'b0);
        tick();
        drive(1, 1, 1'b0);
        tick();
        chk_beat("t3_b0", 1, 0, 1'b0);
        chk("t3_grant", 256'(w_grant), 256'(4'b0010));
        drive(1, 2, 1'b0);
        drive(0, 0, 1'b1);
        drive(3, 0, 1'b1);
        tick();
        idle_q(1);
        idle_q(0);
        idle_q(3);
        chk("t3_q1_nf", 256'(w_s_ready[1]), 256'(1'b0));
        chk_beat("t3_b0_stall", 1, 0, 1'b0);
        r_m_ready = 1'b1;
        tick();
        r_m_ready = 1'b0;
        chk_beat("t3_b1", 1, 1, 1'b0);
        chk("t3_q1_ready", 256'(w_s_ready[1]), 256'(1'b1));
        drive(1, 3, 1'b1);
        tick();
        idle_q(1);
        chk_beat("t3_b1_stall", 1, 1, 1'b0);
        chk("t3_hold1", 256'(w_grant), 256'(4'b0010));
        r_m_ready = 1'b1;
        tick();
        r_m_ready = 1'b0;
        chk_beat("t3_b2", 1, 2, 1'b0);
        tick();
        chk_beat("t3_b2_stall", 1, 2, 1'b0);
        chk("t3_hold2", 256'(w_grant), 256'(4'b0010));
        r_m_ready = 1'b1;
        tick();
        chk_beat("t3_b3", 1, 3, 1'b1);
        tick();
        chk("t3_gap", 256'(m_if.tvalid), 256'(1'b0));
        tick();
        chk_beat("t3_q3", 3, 0, 1'b1);
        chk("t3_q3_grant", 256'(w_grant), 256'(4'b1000));
        tick();
        tick();
        chk_beat("t3_q0", 0, 0, 1'b1);
        chk("t3_q0_grant", 256'(w_grant), 256'(4'b0001));
        tick();
        chk("t3_pkt", 256'(w_pkt), 256'(32'd9));

        // Q0 starves mid-packet while Q3 fills up; grant stays on Q0
        drive(0, 0, 1'b0);
        tick();
        idle_q(0);
        tick();
        chk_beat("t4_b0", 0, 0, 1'b0);
        tick();
        chk("t4_starve_valid", 256'(m_if.tvalid), 256'(1'b0));
        chk("t4_starve_grant", 256'(w_grant), 256'(4'b0001));
        drive(3, 0, 1'b0);
        tick();
        drive(3, 1, 1'b0);
        tick();
        drive(3, 2, 1'b1);
        tick();
        idle_q(3);
        chk("t4_q3_nf", 256'(w_s_ready[3]), 256'(1'b0));
        chk("t4_hold_valid", 256'(m_if.tvalid), 256'(1'b0));
        chk("t4_hold_grant", 256'(w_grant), 256'(4'b0001));
        drive(0, 1, 1'b1);
        tick();
        idle_q(0);
        chk_beat("t4_b1", 0, 1, 1'b1);
        tick();
        chk("t4_gap_grant", 256'(w_grant), 256'(4'b0000));
        tick();
        chk_beat("t4_q3_b0", 3, 0, 1'b0);
        chk("t4_q3_grant", 256'(w_grant), 256'(4'b1000));
        tick();
        chk_beat("t4_q3_b1", 3, 1, 1'b0);
        chk("t4_q3_ready", 256'(w_s_ready[3]), 256'(1'b1));
        tick();
        chk_beat("t4_q3_b2", 3, 2, 1'b1);
        tick();
        chk("t4_pkt", 256'(w_pkt), 256'(32'd11));

        // reset during beat 2 of a 5-beat packet
        drive(2, 0, 1'b0);
        tick();
        drive(2, 1, 1'b0);
        tick();
        chk_beat("t5_b0", 2, 0, 1'b0);
        drive(2, 2, 1'b0);
        tick();
        idle_q(2);
        chk_beat("t5_b1", 2, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 256'(m_if.tvalid), 256'(1'b0));
        chk("t5_async_grant", 256'(w_grant), 256'(4'b0000));
        chk("t5_async_pkt",   256'(w_pkt), 256'(32'd0));
        chk("t5_async_data",  m_if.tdata, 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_state", 256'(dut.r_state), 256'(IDLE));
        chk("t5_pkt",   256'(w_pkt), 256'(32'd0));
        chk("t5_ready", 256'(w_s_ready), 256'(4'hF));
        chk("t5_valid", 256'(m_if.tvalid), 256'(1'b0));

        // packet counter wraps from all-ones to zero
        force dut.r_pkt_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_pkt_count;
        chk("t6_preset", 256'(w_pkt), 256'(32'hFFFF_FFFF));
        drive(1, 0, 1'b1);
        tick();
        idle_q(1);
        tick();
        chk_beat("t6_b0", 1, 0, 1'b1);
        tick();
        chk("t6_wrap", 256'(w_pkt), 256'(32'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
